// File: rtl/fc2_weight_sink.sv
// fc2_weight_sink
//   Receiving end of the fc2 weight stream. Each accepted beat is packed into
//   one RAM word (element j -> bits [W*j +: W]) and stored at wr_count. After
//   IN_DEPTH beats the block parks in DONE with load_done high until clear.
//   A 2-stage ce0-gated read port mirrors the fc2 weight ROM timing.
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous reset, active low
//   data_in[P]     beat elements, W bits each
//   data_in_valid  upstream has a beat
//   data_in_ready  sink accepts a beat this cycle (combinational)
//   clear          synchronous restart of the load (RAM kept)
//   load_done      full tensor stored
//   wr_count       beats stored so far in the current load
//   address0       read address
//   ce0            read pipeline enable
//   q0             read data, 2-cycle latency
//
// state   | meaning
// --------+-----------------------------------------------
// ST_LOAD | accepting beats, wr_count is next write slot
// ST_DONE | tensor complete, RAM frozen, ready low

module fc2_weight_sink #(
  parameter int WEIGHT_TENSOR_SIZE_DIM_0 = 32,
  parameter int WEIGHT_TENSOR_SIZE_DIM_1 = 1,
  parameter int WEIGHT_PRECISION_0       = 16,
  parameter int WEIGHT_PRECISION_1       = 3,
  parameter int WEIGHT_PARALLELISM_DIM_0 = 1,
  parameter int WEIGHT_PARALLELISM_DIM_1 = 1,
  parameter int IN_DEPTH = (WEIGHT_TENSOR_SIZE_DIM_0 * WEIGHT_TENSOR_SIZE_DIM_1) /
                           (WEIGHT_PARALLELISM_DIM_0 * WEIGHT_PARALLELISM_DIM_1),
  localparam int P   = WEIGHT_PARALLELISM_DIM_0 * WEIGHT_PARALLELISM_DIM_1,
  localparam int AW  = $clog2(IN_DEPTH + 1),
  localparam int DW  = WEIGHT_PRECISION_0 * P
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WEIGHT_PRECISION_0-1:0] data_in [P],
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  input  logic                          clear,
  output logic                          load_done,
  output logic [AW-1:0]                 wr_count,
  input  logic [AW-1:0]                 address0,
  input  logic                          ce0,
  output logic [DW-1:0]                 q0
);

  localparam int W   = WEIGHT_PRECISION_0;
  localparam int RAW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;

  // Fractional width is carried for documentation of the number format only.
  localparam int unused_frac_bits = WEIGHT_PRECISION_1;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_count_q, wr_count_d;
  logic [DW-1:0]   rd_stage0_q, rd_stage0_d;
  logic [DW-1:0]   q0_q, q0_d;
  logic [DW-1:0]   mem [IN_DEPTH];
  logic [DW-1:0]   wr_word;
  logic [RAW-1:0]  wr_idx;
  logic [RAW-1:0]  rd_idx;
  logic            accept;
  logic            last_beat;
  logic            unused_addr_bits;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_LOAD;
      wr_count_q  <= '0;
      rd_stage0_q <= '0;
      q0_q        <= '0;
    end else begin
      state_q     <= state_d;
      wr_count_q  <= wr_count_d;
      rd_stage0_q <= rd_stage0_d;
      q0_q        <= q0_d;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_LOAD;
    end else if (accept && last_beat) begin
      state_d = ST_DONE;
    end
  end

  // ---------------------------------------------------------------- outputs
  // rst is folded in so ready is low while reset is held, even combinationally.
  always_comb begin
    data_in_ready = rst && (state_q == ST_LOAD) && !clear;
    load_done     = (state_q == ST_DONE);
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin
    accept    = data_in_valid && data_in_ready;
    last_beat = (wr_count_q == AW'(IN_DEPTH - 1));

    wr_count_d = wr_count_q;
    if (clear) begin
      wr_count_d = '0;
    end else if (accept) begin
      wr_count_d = last_beat ? '0 : wr_count_q + AW'(1);
    end

    wr_word = '0;
    for (int j = 0; j < P; j++) begin
      wr_word[W*j +: W] = data_in[j];
    end

    wr_idx = wr_count_q[RAW-1:0];
    // Out-of-range addresses are not trapped; only the low bits index the RAM.
    rd_idx = address0[RAW-1:0];

    rd_stage0_d = ce0 ? mem[rd_idx] : rd_stage0_q;
    q0_d        = ce0 ? rd_stage0_q : q0_q;
  end

  // RAM contents are deliberately not reset. Non-blocking write gives
  // read-before-write when the same address is read on the same edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_idx] <= wr_word;
    end
  end

  assign unused_addr_bits = ^address0;
  assign wr_count         = wr_count_q;
  assign q0               = q0_q;

endmodule

// File: tb/tb_fc2_weight_sink.sv
module tb_fc2_weight_sink;

  localparam int W      = 16;
  localparam int DEPTH  = 32;
  localparam int AW     = 6;
  localparam int W4     = 8;
  localparam int P4     = 4;
  localparam int DEPTH4 = 8;
  localparam int AW4    = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic [W-1:0]  din [1];
  logic          valid, clear, ready, done, ce0;
  logic [AW-1:0] wr_count, address0;
  logic [W-1:0]  q0;

  // P=4, W=8 instance
  logic [W4-1:0]    d4 [P4];
  logic             v4, c4, ready4, done4, ce4;
  logic [AW4-1:0]   wc4, a4;
  logic [W4*P4-1:0] q4;

  fc2_weight_sink u_dut (
    .clk(clk), .rst(rst), .data_in(din), .data_in_valid(valid),
    .data_in_ready(ready), .clear(clear), .load_done(done),
    .wr_count(wr_count), .address0(address0), .ce0(ce0), .q0(q0)
  );

  fc2_weight_sink #(
    .WEIGHT_TENSOR_SIZE_DIM_0(32), .WEIGHT_PRECISION_0(8),
    .WEIGHT_PARALLELISM_DIM_0(4)
  ) u_dut4 (
    .clk(clk), .rst(rst), .data_in(d4), .data_in_valid(v4),
    .data_in_ready(ready4), .clear(c4), .load_done(done4),
    .wr_count(wc4), .address0(a4), .ce0(ce4), .q0(q4)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: RAM image, handshake count in current load, done flag.
  logic [W-1:0] ref_mem [DEPTH];
  int           ref_cnt  = 0;
  bit           ref_done = 1'b0;
  int           n_hs_dut = 0;

  function automatic void model_edge(input bit v, input bit c, input logic [W-1:0] d);
    if (c) begin
      ref_cnt  = 0;
      ref_done = 1'b0;
    end else if (v && !ref_done) begin
      ref_mem[ref_cnt] = d;
      ref_cnt++;
      if (ref_cnt == DEPTH) begin
        ref_cnt  = 0;
        ref_done = 1'b1;
      end
    end
  endfunction

  // One clock cycle on the default instance, checked against the model.
  task automatic cycle(input bit v, input bit c, input logic [W-1:0] d);
    valid = v; clear = c; din[0] = d;
    #1;
    chk("ready", ready, (!ref_done && !c));
    if (ready && v) n_hs_dut++;
    @(posedge clk);
    model_edge(v, c, d);
    #1;
    chk("wr_count", wr_count, ref_cnt);
    chk("load_done", done, ref_done);
    valid = 1'b0; clear = 1'b0;
  endtask

  task automatic read_all();
    for (int i = 0; i <= DEPTH; i++) begin
      ce0      = 1'b1;
      address0 = (i < DEPTH) ? AW'(i) : '0;
      @(posedge clk);
      #1;
      if (i >= 1) chk("q0_read", q0, ref_mem[i-1]);
    end
    ce0 = 1'b0;
  endtask

  typedef struct {
    bit           v;
    bit           c;
    logic [W-1:0] d;
    bit           e_ready;
    int           e_wc;
    bit           e_done;
  } vec_t;

  vec_t tbl [8];

  logic [W4*P4-1:0] mem4 [DEPTH4];
  logic [W4*P4-1:0] m_st0, m_q;
  int               ra;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    valid = 1'b1; clear = 1'b0; din[0] = '0; ce0 = 1'b0; address0 = '0;
    v4 = 1'b0; c4 = 1'b0; ce4 = 1'b0; a4 = '0;
    for (int j = 0; j < P4; j++) d4[j] = '0;

    tbl[0] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 16'h0001, 1'b1, 2, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 16'hBEEF, 1'b0, 0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 16'h0000, 1'b0, 0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 16'h0007, 1'b1, 1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 16'h0008, 1'b0, 0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 16'h0000, 1'b1, 0, 1'b0};

    // reset values while rst is held low
    #12;
    chk("rst_ready", ready, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_load_done", done, 0);
    chk("rst_q0", q0, 0);
    chk("rst_q0_p4", q4, 0);
    @(posedge clk); #1;
    rst = 1'b1; valid = 1'b0;

    // table-driven short sequence
    for (int k = 0; k < 8; k++) begin
      valid = tbl[k].v; clear = tbl[k].c; din[0] = tbl[k].d;
      #1;
      chk("tbl_ready", ready, tbl[k].e_ready);
      @(posedge clk);
      model_edge(tbl[k].v, tbl[k].c, tbl[k].d);
      #1;
      chk("tbl_wr_count", wr_count, tbl[k].e_wc);
      chk("tbl_load_done", done, tbl[k].e_done);
    end
    valid = 1'b0; clear = 1'b0;

    // back-to-back load 0..31
    n_hs_dut = 0;
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, W'(i));
    chk("b2b_handshakes", n_hs_dut, DEPTH);
    chk("b2b_done", done, 1);
    read_all();

    // DONE: pushing 0xFFFF must not change anything
    n_hs_dut = 0;
    repeat (10) cycle(1'b1, 1'b0, 16'hFFFF);
    chk("done_no_handshake", n_hs_dut, 0);
    read_all();

    // random valid gaps, same data
    cycle(1'b0, 1'b1, '0);
    for (int k = 0; k < 400 && !ref_done; k++) begin
      cycle(1'($urandom_range(0, 1)), 1'b0, W'(ref_cnt));
    end
    chk("rand_done", done, 1);
    read_all();

    // clear collides with a valid beat at wr_count=5
    cycle(1'b0, 1'b1, '0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, W'(16'h2000 + i));
    cycle(1'b1, 1'b1, 16'hDEAD);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, W'(16'h1000 + i));
    read_all();

    // async reset pulse at wr_count=17
    cycle(1'b0, 1'b1, '0);
    for (int i = 0; i < 17; i++) cycle(1'b1, 1'b0, W'(16'h3000 + i));
    rst = 1'b0; valid = 1'b1;
    #1;
    chk("arst_ready", ready, 0);
    chk("arst_wr_count", wr_count, 0);
    chk("arst_load_done", done, 0);
    chk("arst_q0", q0, 0);
    chk("arst_q0_p4", q4, 0);
    ref_cnt = 0; ref_done = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, W'(16'h4000 + i));
    read_all();

    // P=4, W=8 instance: packing and ce0 freeze
    for (int k = 0; k < DEPTH4; k++) begin
      if (k == 0) begin
        d4[0] = 8'h11; d4[1] = 8'h22; d4[2] = 8'h33; d4[3] = 8'h44;
        mem4[0] = 32'h4433_2211;
      end else begin
        mem4[k] = '0;
        for (int j = 0; j < P4; j++) begin
          d4[j]   = 8'($urandom_range(0, 255));
          mem4[k] = mem4[k] + (32'(d4[j]) << (8 * j));
        end
      end
      v4 = 1'b1;
      #1;
      chk("p4_ready", ready4, 1);
      @(posedge clk); #1;
    end
    v4 = 1'b0;
    chk("p4_done", done4, 1);
    chk("p4_wr_count", wc4, 0);

    m_st0 = '0; m_q = '0; ra = 0;
    for (int s = 0; s < 12; s++) begin
      ce4 = !(s >= 4 && s <= 6);
      a4  = (ra < DEPTH4) ? AW4'(ra) : '0;
      @(posedge clk);
      if (ce4) begin
        m_q   = m_st0;
        m_st0 = mem4[a4];
        ra++;
      end
      #1;
      chk("p4_q0", q4, m_q);
    end
    ce4 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
